// File: rtl/vanilla_sb_profiler_pkg.sv
// Shared types and helpers for the vanilla scoreboard stall profiler: scoreboard
// info structs, attribution categories and the info-to-category mapping.
package vanilla_sb_profiler_pkg;

  localparam int RV32_reg_els_gp = 32;
  localparam int sb_num_ctrs_gp  = 13;
  localparam int sb_dump_last_gp = 13;
  localparam int sb_num_cand_gp  = 12;

  typedef enum logic [3:0] {
    SB_CAT_IDIV            = 4'd0,
    SB_CAT_INT_DRAM_LOAD   = 4'd1,
    SB_CAT_INT_DRAM_AMO    = 4'd2,
    SB_CAT_INT_DMEM_OVF    = 4'd3,
    SB_CAT_INT_GLOBAL_LOAD = 4'd4,
    SB_CAT_INT_GROUP_LOAD  = 4'd5,
    SB_CAT_INT_GROUP_AMO   = 4'd6,
    SB_CAT_FDIV_FSQRT      = 4'd7,
    SB_CAT_FP_DRAM_LOAD    = 4'd8,
    SB_CAT_FP_GLOBAL_LOAD  = 4'd9,
    SB_CAT_FP_GROUP_LOAD   = 4'd10,
    SB_CAT_FP_DMEM_OVF     = 4'd11,
    SB_CAT_UNATTR          = 4'd12,
    SB_CAT_MAX_AGE         = 4'd13
  } sb_cat_e;

  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_DUMP = 1'b1
  } sb_state_e;

  typedef struct packed {
    logic idiv;
    logic remote_dram_load;
    logic remote_dram_amo;
    logic remote_dmem_overflow_load;
    logic remote_global_load;
    logic remote_group_load;
    logic remote_group_amo;
  } vanilla_isb_info_s;

  typedef struct packed {
    logic fdiv_fsqrt;
    logic remote_dram_load;
    logic remote_global_load;
    logic remote_group_load;
    logic remote_dmem_overflow_load;
  } vanilla_fsb_info_s;

  // Scatter one operand's scoreboard bits onto the attribution category positions.
  function automatic logic [sb_num_cand_gp-1:0] sb_cat_bits(
    input vanilla_isb_info_s isb, input logic int_en,
    input vanilla_fsb_info_s fsb, input logic fp_en);
    logic [sb_num_cand_gp-1:0] bits;
    bits                         = 12'b0;
    bits[SB_CAT_IDIV]            = int_en & isb.idiv;
    bits[SB_CAT_INT_DRAM_LOAD]   = int_en & isb.remote_dram_load;
    bits[SB_CAT_INT_DRAM_AMO]    = int_en & isb.remote_dram_amo;
    bits[SB_CAT_INT_DMEM_OVF]    = int_en & isb.remote_dmem_overflow_load;
    bits[SB_CAT_INT_GLOBAL_LOAD] = int_en & isb.remote_global_load;
    bits[SB_CAT_INT_GROUP_LOAD]  = int_en & isb.remote_group_load;
    bits[SB_CAT_INT_GROUP_AMO]   = int_en & isb.remote_group_amo;
    bits[SB_CAT_FDIV_FSQRT]      = fp_en & fsb.fdiv_fsqrt;
    bits[SB_CAT_FP_DRAM_LOAD]    = fp_en & fsb.remote_dram_load;
    bits[SB_CAT_FP_GLOBAL_LOAD]  = fp_en & fsb.remote_global_load;
    bits[SB_CAT_FP_GROUP_LOAD]   = fp_en & fsb.remote_group_load;
    bits[SB_CAT_FP_DMEM_OVF]     = fp_en & fsb.remote_dmem_overflow_load;
    return bits;
  endfunction

endpackage

// File: rtl/vanilla_sb_age_tracker.sv
// Per-register scoreboard lifetime counters for one register file, plus the
// largest age currently held in that file.
module vanilla_sb_age_tracker
  import vanilla_sb_profiler_pkg::*;
#(
  parameter int reg_els_p   = RV32_reg_els_gp,
  parameter int age_width_p = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [reg_els_p-1:0]   busy_i,
  output logic [age_width_p-1:0] max_age_o
);

  logic [age_width_p-1:0] age_r [reg_els_p];
  logic [age_width_p-1:0] max_age_s;

  // Count consecutive busy cycles per register, saturating; idle drops to zero.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < reg_els_p; i++) begin
      if (!reset_n_i) begin
        age_r[i] <= '0;
      end else if (!busy_i[i]) begin
        age_r[i] <= '0;
      end else if (age_r[i] != {age_width_p{1'b1}}) begin
        age_r[i] <= age_r[i] + age_width_p'(1);
      end else begin
        age_r[i] <= age_r[i];
      end
    end
  end

  // Largest age currently held in this file.
  always_comb begin
    max_age_s = '0;
    for (int i = 0; i < reg_els_p; i++) begin
      if (age_r[i] > max_age_s) begin
        max_age_s = age_r[i];
      end else begin
        max_age_s = max_age_s;
      end
    end
  end

  assign max_age_o = max_age_s;

endmodule

// File: rtl/vanilla_sb_stall_profiler.sv
// Attributes ID dependency-stall cycles to scoreboard causes, tracks the longest
// scoreboard lifetime, and drains the results through a valid/yumi dump stream.
module vanilla_sb_stall_profiler
  import vanilla_sb_profiler_pkg::*;
#(
  parameter int ctr_width_p = 32,
  parameter int age_width_p = 16,
  parameter int reg_els_p   = RV32_reg_els_gp
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  vanilla_isb_info_s [reg_els_p-1:0] int_sb_i,
  input  vanilla_fsb_info_s [reg_els_p-1:0] float_sb_i,
  input  logic                              stall_depend_i,
  input  logic                              stall_all_i,
  input  logic [2:0][4:0]                   id_rs_addr_i,
  input  logic [2:0]                        id_rs_int_i,
  input  logic [2:0]                        id_rs_fp_i,
  input  logic                              dump_v_i,
  output logic                              dump_v_o,
  output logic [3:0]                        dump_id_o,
  output logic [ctr_width_p-1:0]            dump_data_o,
  input  logic                              dump_yumi_i,
  output logic                              busy_o
);

  sb_state_e                 state_r, state_n;
  logic [3:0]                idx_r, idx_n;
  logic [ctr_width_p-1:0]    ctr_r [sb_num_ctrs_gp];
  logic [age_width_p-1:0]    max_age_r;
  logic [age_width_p-1:0]    int_max_s, fp_max_s, max_all_s;
  logic [reg_els_p-1:0]      int_busy_s, fp_busy_s;
  logic [sb_num_cand_gp-1:0] cand_s;
  logic [3:0]                inc_sel_s;
  logic [ctr_width_p-1:0]    dump_data_s;
  logic                      qual_s, clear_s;

  // Register busy flags feeding the per-file age trackers.
  always_comb begin
    int_busy_s = '0;
    fp_busy_s  = '0;
    for (int i = 0; i < reg_els_p; i++) begin
      int_busy_s[i] = |int_sb_i[i];
      fp_busy_s[i]  = |float_sb_i[i];
    end
  end

  vanilla_sb_age_tracker #(.reg_els_p(reg_els_p), .age_width_p(age_width_p)) int_age (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .busy_i(int_busy_s), .max_age_o(int_max_s));

  vanilla_sb_age_tracker #(.reg_els_p(reg_els_p), .age_width_p(age_width_p)) fp_age (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .busy_i(fp_busy_s), .max_age_o(fp_max_s));

  assign max_all_s = (int_max_s > fp_max_s) ? int_max_s : fp_max_s;

  // Union of scoreboard causes over the operands ID actually reads; x0 is never busy.
  always_comb begin
    cand_s = '0;
    for (int k = 0; k < 3; k++) begin
      cand_s = cand_s | sb_cat_bits(int_sb_i[id_rs_addr_i[k]],
                                    id_rs_int_i[k] && (id_rs_addr_i[k] != 5'd0),
                                    float_sb_i[id_rs_addr_i[k]], id_rs_fp_i[k]);
    end
  end

  // Lowest-index cause wins; no cause at all lands in the unattributed bucket.
  always_comb begin
    inc_sel_s = SB_CAT_UNATTR;
    for (int c = sb_num_cand_gp - 1; c >= 0; c--) begin
      if (cand_s[c]) begin
        inc_sel_s = 4'(c);
      end else begin
        inc_sel_s = inc_sel_s;
      end
    end
  end

  assign qual_s  = stall_depend_i & ~stall_all_i & (state_r == SB_IDLE);
  assign clear_s = (state_r == SB_DUMP) & dump_yumi_i & (idx_r == 4'(sb_dump_last_gp));

  // Saturating attribution counters, wiped when the last dump entry is taken.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < sb_num_ctrs_gp; i++) begin
      if (!reset_n_i || clear_s) begin
        ctr_r[i] <= '0;
      end else if (qual_s && (inc_sel_s == 4'(i)) && (ctr_r[i] != {ctr_width_p{1'b1}})) begin
        ctr_r[i] <= ctr_r[i] + ctr_width_p'(1);
      end else begin
        ctr_r[i] <= ctr_r[i];
      end
    end
  end

  // Running maximum of all register ages.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i || clear_s) begin
      max_age_r <= '0;
    end else if (max_all_s > max_age_r) begin
      max_age_r <= max_all_s;
    end else begin
      max_age_r <= max_age_r;
    end
  end

  // Dump FSM state and entry index.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= SB_IDLE;
      idx_r   <= 4'd0;
    end else begin
      state_r <= state_n;
      idx_r   <= idx_n;
    end
  end

  // Dump FSM next state: requests are ignored mid-dump, yumi walks the entries.
  always_comb begin
    state_n = state_r;
    idx_n   = idx_r;
    case (state_r)
      SB_IDLE: begin
        idx_n = 4'd0;
        if (dump_v_i) begin
          state_n = SB_DUMP;
        end else begin
          state_n = SB_IDLE;
        end
      end
      SB_DUMP: begin
        if (dump_yumi_i && (idx_r == 4'(sb_dump_last_gp))) begin
          state_n = SB_IDLE;
          idx_n   = 4'd0;
        end else if (dump_yumi_i) begin
          idx_n = idx_r + 4'd1;
        end else begin
          idx_n = idx_r;
        end
      end
      default: begin
        state_n = SB_IDLE;
        idx_n   = 4'd0;
      end
    endcase
  end

  // Current dump entry; counters are frozen while dumping so this stays stable.
  always_comb begin
    dump_data_s = '0;
    if (state_r != SB_DUMP) begin
      dump_data_s = '0;
    end else if (idx_r == SB_CAT_MAX_AGE) begin
      dump_data_s = ctr_width_p'(max_age_r);
    end else begin
      for (int i = 0; i < sb_num_ctrs_gp; i++) begin
        if (idx_r == 4'(i)) begin
          dump_data_s = ctr_r[i];
        end else begin
          dump_data_s = dump_data_s;
        end
      end
    end
  end

  assign dump_v_o    = (state_r == SB_DUMP);
  assign busy_o      = (state_r == SB_DUMP);
  assign dump_id_o   = idx_r;
  assign dump_data_o = dump_data_s;

endmodule

// File: tb/tb_vanilla_sb_stall_profiler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// cause-list / streak-length reference model, on a 32-bit and a 4-bit instance.
module tb_vanilla_sb_stall_profiler;
  import vanilla_sb_profiler_pkg::*;

  logic clk = 1'b0;
  logic reset_n_i;
  vanilla_isb_info_s [31:0] int_sb_i;
  vanilla_fsb_info_s [31:0] float_sb_i;
  logic stall_depend_i, stall_all_i, dump_v_i, dump_yumi_i;
  logic [2:0][4:0] id_rs_addr_i;
  logic [2:0] id_rs_int_i, id_rs_fp_i;
  logic dump_v_o, busy_o, dump_v4, busy4;
  logic [3:0] dump_id_o, dump_id4, dump_data4;
  logic [31:0] dump_data_o;

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_cnt [13];
  int m_max;
  int m_si [32];
  int m_sf [32];
  bit m_dump;
  int m_idx;
  logic [31:0] dumped [14];

  always #5 clk = ~clk;

  vanilla_sb_stall_profiler dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .int_sb_i(int_sb_i), .float_sb_i(float_sb_i),
    .stall_depend_i(stall_depend_i), .stall_all_i(stall_all_i), .id_rs_addr_i(id_rs_addr_i),
    .id_rs_int_i(id_rs_int_i), .id_rs_fp_i(id_rs_fp_i), .dump_v_i(dump_v_i),
    .dump_v_o(dump_v_o), .dump_id_o(dump_id_o), .dump_data_o(dump_data_o),
    .dump_yumi_i(dump_yumi_i), .busy_o(busy_o));

  vanilla_sb_stall_profiler #(.ctr_width_p(4)) dut4 (
    .clk_i(clk), .reset_n_i(reset_n_i), .int_sb_i(int_sb_i), .float_sb_i(float_sb_i),
    .stall_depend_i(stall_depend_i), .stall_all_i(stall_all_i), .id_rs_addr_i(id_rs_addr_i),
    .id_rs_int_i(id_rs_int_i), .id_rs_fp_i(id_rs_fp_i), .dump_v_i(dump_v_i),
    .dump_v_o(dump_v4), .dump_id_o(dump_id4), .dump_data_o(dump_data4),
    .dump_yumi_i(dump_yumi_i), .busy_o(busy4));

  // Category chosen by the spec rule: smallest index among all causes on read operands.
  function automatic int model_cat();
    int best = 12;
    int causes[$];
    for (int k = 0; k < 3; k++) begin
      vanilla_isb_info_s ib = int_sb_i[id_rs_addr_i[k]];
      vanilla_fsb_info_s fb = float_sb_i[id_rs_addr_i[k]];
      if (id_rs_int_i[k] && id_rs_addr_i[k] != 5'd0) begin
        if (ib.idiv) causes.push_back(0);
        if (ib.remote_dram_load) causes.push_back(1);
        if (ib.remote_dram_amo) causes.push_back(2);
        if (ib.remote_dmem_overflow_load) causes.push_back(3);
        if (ib.remote_global_load) causes.push_back(4);
        if (ib.remote_group_load) causes.push_back(5);
        if (ib.remote_group_amo) causes.push_back(6);
      end
      if (id_rs_fp_i[k]) begin
        if (fb.fdiv_fsqrt) causes.push_back(7);
        if (fb.remote_dram_load) causes.push_back(8);
        if (fb.remote_global_load) causes.push_back(9);
        if (fb.remote_group_load) causes.push_back(10);
        if (fb.remote_dmem_overflow_load) causes.push_back(11);
      end
    end
    foreach (causes[i]) if (causes[i] < best) best = causes[i];
    return best;
  endfunction

  // Apply what the coming clock edge does to the model, given the current inputs.
  function automatic void model_edge();
    bit clr = 1'b0;
    if (!reset_n_i) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      foreach (m_si[i]) begin m_si[i] = 0; m_sf[i] = 0; end
      m_max = 0; m_dump = 1'b0; m_idx = 0;
      return;
    end
    if (stall_depend_i && !stall_all_i && !m_dump) m_cnt[model_cat()]++;
    for (int i = 0; i < 32; i++) begin
      m_si[i] = (int_sb_i[i] != '0) ? ((m_si[i] < 65535) ? m_si[i] + 1 : 65535) : 0;
      m_sf[i] = (float_sb_i[i] != '0) ? ((m_sf[i] < 65535) ? m_sf[i] + 1 : 65535) : 0;
      if (m_si[i] > m_max) m_max = m_si[i];
      if (m_sf[i] > m_max) m_max = m_sf[i];
    end
    if (!m_dump) begin
      if (dump_v_i) begin m_dump = 1'b1; m_idx = 0; end
    end else if (dump_yumi_i) begin
      if (m_idx == 13) begin m_dump = 1'b0; m_idx = 0; clr = 1'b1; end
      else m_idx++;
    end
    if (clr) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_max = 0;
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    int_sb_i = '0; float_sb_i = '0;
    stall_depend_i = 1'b0; stall_all_i = 1'b0;
    id_rs_addr_i = '0; id_rs_int_i = 3'b000; id_rs_fp_i = 3'b000;
    dump_v_i = 1'b0; dump_yumi_i = 1'b0;
  endtask

  task automatic settle();
    quiet_inputs();
    repeat (3) tick();
  endtask

  // Drain all 14 entries with random yumi gaps; stall/dump requests during DUMP must be ignored.
  task automatic run_dump(input string tag);
    logic [31:0] exp32;
    logic [3:0] exp4;
    dump_v_i = 1'b1;
    tick();
    dump_v_i = 1'b0;
    for (int e = 0; e <= 13; e++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        dump_yumi_i = 1'b0;
        stall_depend_i = 1'($urandom);
        dump_v_i = 1'($urandom);
        tick();
      end
      exp32 = (e == 13) ? 32'(m_max) : 32'(m_cnt[e]);
      exp4  = (e == 13) ? 4'(m_max) : ((m_cnt[e] > 15) ? 4'd15 : 4'(m_cnt[e]));
      checks++;
      if (dump_v_o !== 1'b1 || busy_o !== 1'b1 || dump_v4 !== 1'b1 || busy4 !== 1'b1) begin
        errors++;
        $display("FAIL %s valid/busy entry %0d: got v=%b b=%b v4=%b b4=%b expected all 1", tag, e, dump_v_o, busy_o, dump_v4, busy4);
      end
      checks++;
      if (dump_id_o !== 4'(e) || dump_id4 !== 4'(e)) begin
        errors++;
        $display("FAIL %s id: got %0d/%0d expected %0d", tag, dump_id_o, dump_id4, e);
      end
      checks++;
      if (dump_data_o !== exp32) begin
        errors++;
        $display("FAIL %s data entry %0d: got %0d expected %0d", tag, e, dump_data_o, exp32);
      end
      checks++;
      if (dump_data4 !== exp4) begin
        errors++;
        $display("FAIL %s data4 entry %0d: got %0d expected %0d", tag, e, dump_data4, exp4);
      end
      dumped[e] = dump_data_o;
      dump_yumi_i = 1'b1;
      stall_depend_i = 1'($urandom);
      dump_v_i = (e == 13) ? 1'b0 : 1'($urandom);
      tick();
      dump_yumi_i = 1'b0;
    end
    quiet_inputs();
    checks++;
    if (dump_v_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s end: got v=%b busy=%b expected 0 0", tag, dump_v_o, busy_o);
    end
  endtask

  task automatic check_entry(input string tag, input int e, input logic [31:0] expv);
    checks++;
    if (dumped[e] !== expv) begin
      errors++;
      $display("FAIL %s entry %0d: got %0d expected %0d", tag, e, dumped[e], expv);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (dump_v_o !== 1'b0 || busy_o !== 1'b0 || dump_id_o !== 4'd0 || dump_data_o !== 32'd0 ||
        dump_v4 !== 1'b0 || busy4 !== 1'b0 || dump_id4 !== 4'd0 || dump_data4 !== 4'd0) begin
      errors++;
      $display("FAIL %s: got v=%b busy=%b id=%0d data=%0d v4=%b id4=%0d expected zeros", tag,
               dump_v_o, busy_o, dump_id_o, dump_data_o, dump_v4, dump_id4);
    end
  endtask

  task automatic test_reset();
    quiet_inputs();
    reset_n_i = 1'b0;
    tick(); tick();
    check_idle_outputs("reset_outputs");
    reset_n_i = 1'b1;
    tick();
    run_dump("reset_dump");
    for (int e = 0; e <= 13; e++) check_entry("reset_zero", e, 32'd0);
  endtask

  task automatic test_dram_load();
    quiet_inputs();
    int_sb_i[5].remote_dram_load = 1'b1;
    id_rs_addr_i[0] = 5'd5; id_rs_int_i = 3'b001;
    stall_depend_i = 1'b1;
    repeat (10) tick();
    settle();
    run_dump("dram_load");
    for (int e = 0; e < 13; e++) check_entry("dram_load", e, (e == 1) ? 32'd10 : 32'd0);
  endtask

  task automatic test_priority();
    quiet_inputs();
    int_sb_i[5].idiv = 1'b1;
    float_sb_i[5].remote_global_load = 1'b1;
    id_rs_addr_i[0] = 5'd5; id_rs_addr_i[1] = 5'd5;
    id_rs_int_i = 3'b001; id_rs_fp_i = 3'b010;
    stall_depend_i = 1'b1;
    repeat (4) tick();
    settle();
    run_dump("priority");
    check_entry("priority_idiv", 0, 32'd4);
    check_entry("priority_fglobal", 9, 32'd0);
  endtask

  task automatic test_unattributed();
    quiet_inputs();
    stall_depend_i = 1'b1;
    repeat (6) tick();
    stall_all_i = 1'b1;
    repeat (3) tick();
    settle();
    run_dump("unattr");
    check_entry("unattr", 12, 32'd6);
  endtask

  task automatic test_max_age();
    quiet_inputs();
    float_sb_i[3].fdiv_fsqrt = 1'b1;
    repeat (20) tick();
    float_sb_i[3] = '0;
    int_sb_i[7].remote_group_load = 1'b1;
    repeat (7) tick();
    settle();
    run_dump("max_age");
    check_entry("max_age", 13, 32'd20);
    run_dump("max_age_redump");
    for (int e = 0; e <= 13; e++) check_entry("redump_zero", e, 32'd0);
  endtask

  task automatic test_saturation();
    quiet_inputs();
    int_sb_i[2].remote_global_load = 1'b1;
    id_rs_addr_i[0] = 5'd2; id_rs_int_i = 3'b001;
    stall_depend_i = 1'b1;
    repeat (20) tick();
    settle();
    run_dump("saturate");
    check_entry("saturate_wide", 4, 32'd20);
  endtask

  task automatic test_reset_mid_dump();
    quiet_inputs();
    stall_depend_i = 1'b1;
    repeat (5) tick();
    quiet_inputs();
    dump_v_i = 1'b1;
    tick();
    dump_v_i = 1'b0;
    dump_yumi_i = 1'b1;
    repeat (6) tick();
    dump_yumi_i = 1'b0;
    reset_n_i = 1'b0;
    tick();
    check_idle_outputs("reset_mid_dump");
    reset_n_i = 1'b1;
    tick();
    check_idle_outputs("after_reset_idle");
    run_dump("post_reset");
    for (int e = 0; e <= 13; e++) check_entry("post_reset_zero", e, 32'd0);
  endtask

  task automatic test_random(input int cycles);
    quiet_inputs();
    for (int c = 0; c < cycles; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int r = $urandom_range(0, 4);
        int_sb_i[r]   = vanilla_isb_info_s'(7'($urandom & $urandom));
        float_sb_i[r] = vanilla_fsb_info_s'(5'($urandom & $urandom));
      end
      for (int k = 0; k < 3; k++) id_rs_addr_i[k] = 5'($urandom_range(0, 4));
      id_rs_int_i = 3'($urandom);
      id_rs_fp_i = 3'($urandom);
      stall_depend_i = ($urandom_range(0, 3) != 0);
      stall_all_i = ($urandom_range(0, 7) == 0);
      dump_yumi_i = ($urandom_range(0, 9) == 0);
      tick();
    end
    settle();
    run_dump("random");
  endtask

  initial begin
    reset_n_i = 1'b0;
    quiet_inputs();
    test_reset();
    test_dram_load();
    test_priority();
    test_unattributed();
    test_max_age();
    test_saturation();
    test_reset_mid_dump();
    for (int n = 0; n < 4; n++) test_random(300);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vanilla_sb_stall_profiler.md
# vanilla_sb_stall_profiler

Testbench-side profiler that sits directly downstream of the vanilla core's scoreboard tracker. Each cycle it consumes the per-register integer and float scoreboard info vectors together with the ID-stage dependency-stall status. It attributes every dependency-stall cycle to exactly one scoreboard cause and tracks the longest outstanding scoreboard lifetime. Its saturating counters are drained through a valid/yumi dump stream.

## Interface
Parameters:
- ctr_width_p, 32, width of each attribution counter.
- age_width_p, 16, width of per-register age counters and the max-age register.
- reg_els_p, RV32_reg_els_gp, number of architectural registers per file.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset; one clock, reset is synchronous and active-low.
- int_sb_i  in  reg_els_p x vanilla_isb_info_s  integer scoreboard bits per register.
- float_sb_i  in  reg_els_p x vanilla_fsb_info_s  float scoreboard bits per register.
- stall_depend_i  in  1  ID is stalled on a register dependency this cycle.
- stall_all_i  in  1  whole-pipeline stall this cycle.
- id_rs_addr_i  in  3x5  operand register addresses in ID (rs1, rs2, rs3).
- id_rs_int_i  in  3  operand k reads the integer file.
- id_rs_fp_i  in  3  operand k reads the float file.
- dump_v_i  in  1  request a counter dump.
- dump_v_o  out  1  dump entry valid.
- dump_id_o  out  4  category index of the current entry.
- dump_data_o  out  ctr_width_p  counter value of the current entry.
- dump_yumi_i  in  1  consumer takes the current entry.
- busy_o  out  1  dump in progress.

## Operation
- Categories, by index: 0 idiv, 1 int remote_dram_load, 2 int remote_dram_amo, 3 int remote_dmem_overflow_load, 4 int remote_global_load, 5 int remote_group_load, 6 int remote_group_amo, 7 fdiv_fsqrt, 8 float remote_dram_load, 9 float remote_global_load, 10 float remote_group_load, 11 float remote_dmem_overflow_load, 12 unattributed, 13 max_age. Category 13 is a read-only dump entry, not a stall counter.
- Qualifying cycle: stall_depend_i & ~stall_all_i & state==IDLE.
- Candidate bits are the union, over operands k, of int_sb_i[id_rs_addr_i[k]] when id_rs_int_i[k] is set and float_sb_i[id_rs_addr_i[k]] when id_rs_fp_i[k] is set.
- Register x0 never contributes, even if its int_sb bits are set.
- On a qualifying cycle, exactly one counter increments: the lowest-index category whose candidate bit is set. If no candidate bit is set, category 12 increments.
- Counters saturate at all-ones and do not wrap.
- Age: each register has a separate age counter per file. It increments every cycle in which any scoreboard bit of that register is set, regardless of stalls or state. It returns to 0 in the cycle after all bits clear. It saturates at all-ones of age_width_p.
- max_age holds the running maximum of all ages, updated every cycle. It is zero-extended to ctr_width_p in dump entry 13.
- FSM:
  - IDLE→DUMP when dump_v_i=1.
  - In DUMP, index idx starts at 0, dump_v_o=1 and dump_id_o=idx. dump_yumi_i advances idx.
  - A yumi at idx=13 returns the FSM to IDLE and zeroes all 13 counters and max_age in that same edge. Per-register ages are not cleared.
- dump_v_i is ignored while in DUMP.
- Stall cycles that occur during DUMP are dropped, not counted.
- dump_yumi_i is legal only when dump_v_o=1. A yumi while dump_v_o=0 is a bench error and has no effect.

## Timing
- Reset (reset_n_i=0 at an edge): all counters, ages and max_age are 0, the FSM is in IDLE, dump_v_o=0, dump_id_o=0, dump_data_o=0 and busy_o=0.
- Reset mid-dump aborts the dump with no further entries.
- A counter reflects a qualifying cycle N at cycle N+1.
- dump_v_o and busy_o rise one cycle after dump_v_i is sampled.
- dump_data_o is combinational from the counter selected by idx. Counters are frozen in DUMP, so the value is stable until yumi.
- A full dump with yumi held high takes 14 cycles. busy_o falls the cycle after the final yumi.
- Age boundary: a bit set for exactly one cycle yields age 1 and max_age ≥ 1.

## Structure
- The shared package vanilla_sb_profiler_pkg holds:
  - the category enum (sb_cat_e, 4 bits);
  - the constant sb_num_ctrs_gp=13;
  - sb_dump_last_gp=13;
  - the function mapping isb/fsb info structs to a category bit vector.
- Sub-module vanilla_sb_age_tracker: reg_els_p ages for one register file plus its local max. It is instantiated twice, once per file, and the top level takes the max of the two.

## Test plan
- int_sb_i[5].remote_dram_load=1, rs1=5 int, stall_depend_i for 10 cycles, then dump → entry 1 = 10, all other stall entries = 0.
- int_sb_i[5].idiv=1, float_sb_i[5].remote_global_load=1, rs1=5 int, rs2=5 fp, 4 stall cycles → entry 0 = 4, entry 9 = 0.
- 6 stall cycles with no candidate bits, plus 3 more with stall_all_i=1 → entry 12 = 6.
- float_sb_i[3].fdiv_fsqrt held for 20 cycles, then int_sb_i[7] held for 7 cycles → entry 13 = 20. A second dump immediately after gives all entries = 0.
- With ctr_width_p=4, 20 stall cycles on category 4 → entry 4 = 15.
- Start a dump, yumi entries 0–5, deassert reset_n_i → dump_v_o=0 next cycle. A new dump returns all zeros.
